md_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the E stage, alongside the ALU.
- Takes operands from the E-stage forwarding muxes.
- Holds the architectural HI/LO registers.
- Drives busy to the hazard unit so MFHI/MFLO/MULT/DIV in D stall while an operation is in flight.
- HI/LO read data goes into the ALUout mux ahead of the E→M pipeline register.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/md_unit_if.sv | 24 ++
 rtl/md_core.sv | 60 ++++++
 rtl/md_unit.sv | 99 +++++++++
 tb/tb_md_unit.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation
// encodings and default busy durations.
package mips_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MADD  = 4'd7,
        MADDU = 4'd8,
        MSUB  = 4'd9,
        MSUBU = 4'd10
    } md_op_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_unit_if.sv
// Handshake and result bundle between the E stage and the multiply/divide unit.
interface md_unit_if;
    import mips_pkg::*;

    logic        start;
    md_op_e      md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        we_hilo;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, a, b, we_hilo,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, a, b, we_hilo,
        output busy, hi, lo
    );

endinterface

// File: rtl/md_core.sv
// Combinational 64-bit result generator for the multiply/divide unit.
// MD_MADD_EN adds the multiply-accumulate/subtract operations.
module md_core
    import mips_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] new_hi,
    output logic [31:0] new_lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;

    // Full-width products; sign extension makes the low 64 bits exact.
    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'h0, a} * {32'h0, b};
    end

    // Select the result; anything without a defined result keeps HI/LO.
    always_comb begin
        new_hi = hi;
        new_lo = lo;
        case (op)
            MULT:  {new_hi, new_lo} = prod_s;
            MULTU: {new_hi, new_lo} = prod_u;
            DIV: begin
                // Divide by zero leaves HI/LO untouched.
                if (b != 32'h0) begin
                    if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
                        // Quotient overflows; wraps to the dividend, no remainder.
                        new_lo = 32'h8000_0000;
                        new_hi = 32'h0;
                    end else begin
                        new_lo = $signed(a) / $signed(b);
                        new_hi = $signed(a) % $signed(b);
                    end
                end
            end
            DIVU: begin
                if (b != 32'h0) begin
                    new_lo = a / b;
                    new_hi = a % b;
                end
            end
`ifdef MD_MADD_EN
            MADD:  {new_hi, new_lo} = {hi, lo} + prod_s;
            MADDU: {new_hi, new_lo} = {hi, lo} + prod_u;
            MSUB:  {new_hi, new_lo} = {hi, lo} - prod_s;
            MSUBU: {new_hi, new_lo} = {hi, lo} - prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multi-cycle multiply/divide unit holding the HI/LO registers.
// MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU; otherwise those codes are no-ops.
module md_unit
    import mips_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic       clk,
    input logic       reset,
    md_unit_if.slave  bus
);

    localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    md_op_e           op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    logic             busy;
    logic             mult_class;
    logic             div_class;
    logic             accept;
    logic             done;
    logic             hilo_wr;
    logic [31:0]      core_hi;
    logic [31:0]      core_lo;

    // Decode which incoming ops start a multi-cycle operation.
    always_comb begin
        mult_class = (bus.md_op == MULT) || (bus.md_op == MULTU);
`ifdef MD_MADD_EN
        mult_class = mult_class || (bus.md_op == MADD) || (bus.md_op == MADDU) ||
                     (bus.md_op == MSUB) || (bus.md_op == MSUBU);
`endif
        div_class  = (bus.md_op == DIV) || (bus.md_op == DIVU);
    end

    // Handshake qualifiers; a start in the same cycle always suppresses MTHI/MTLO.
    always_comb begin
        busy    = (cnt_q != '0);
        accept  = bus.start && !busy && (mult_class || div_class);
        done    = (cnt_q == CNT_W'(1));
        hilo_wr = bus.we_hilo && !busy && !bus.start;
    end

    // Latch operands on acceptance and count the operation down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            op_q  <= NONE;
            a_q   <= 32'h0;
            b_q   <= 32'h0;
        end else if (accept) begin
            cnt_q <= div_class ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            op_q  <= bus.md_op;
            a_q   <= bus.a;
            b_q   <= bus.b;
        end else if (busy) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    md_core u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi     (hi_q),
        .lo     (lo_q),
        .new_hi (core_hi),
        .new_lo (core_lo)
    );

    // Commit the result on the final countdown edge, or an idle MTHI/MTLO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= 32'h0;
            lo_q <= 32'h0;
        end else if (done) begin
            hi_q <= core_hi;
            lo_q <= core_lo;
        end else if (hilo_wr) begin
            if (bus.md_op == MTHI) begin
                hi_q <= bus.a;
            end else if (bus.md_op == MTLO) begin
                lo_q <= bus.a;
            end
        end
    end

    assign bus.busy = busy;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed scoreboard bench for md_unit.
module tb_md_unit;
    import mips_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    exp_t sb[$];

    md_unit_if bus ();

    md_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.md_op = NONE;
        bus.a     = 32'h0;
        bus.b     = 32'h0;
    endtask

    task automatic write_hilo(input md_op_e op, input logic [31:0] val);
        bus.we_hilo = 1'b1;
        bus.md_op   = op;
        bus.a       = val;
        @(posedge clk);
        #1;
        bus.we_hilo = 1'b0;
        bus.md_op   = NONE;
        bus.a       = 32'h0;
    endtask

    task automatic push(input string tag, input logic [31:0] hi, input logic [31:0] lo,
                        input int cycles);
        exp_t e;
        e.tag    = tag;
        e.hi     = hi;
        e.lo     = lo;
        e.cycles = cycles;
        sb.push_back(e);
    endtask

    // pre: edges already elapsed since the start edge with busy still high.
    task automatic wait_done(input int pre);
        exp_t e;
        int   n;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            n = pre;
            while (bus.busy && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            check({e.tag, "_cycles"}, 32'(n), 32'(e.cycles));
            check({e.tag, "_hi"}, bus.hi, e.hi);
            check({e.tag, "_lo"}, bus.lo, e.lo);
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.md_op   = NONE;
        bus.a       = 32'h0;
        bus.b       = 32'h0;
        bus.we_hilo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_hi", bus.hi, 32'h0);
        check("reset_lo", bus.lo, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        issue(MULT, 32'hffff_fffe, 32'h3);
        push("mult", 32'hffff_ffff, 32'hffff_fffa, 5);
        wait_done(0);

        issue(MULTU, 32'hffff_ffff, 32'hffff_ffff);
        push("multu", 32'hffff_fffe, 32'h0000_0001, 5);
        wait_done(0);

        issue(DIV, 32'hffff_fff9, 32'h2);
        push("div", 32'hffff_ffff, 32'hffff_fffd, 10);
        wait_done(0);

        issue(DIV, 32'h8000_0000, 32'hffff_ffff);
        push("div_ovf", 32'h0, 32'h8000_0000, 10);
        wait_done(0);

        issue(DIVU, 32'd100, 32'd7);
        push("divu", 32'd2, 32'd14, 10);
        wait_done(0);

        write_hilo(MTHI, 32'h11);
        check("mthi_hi", bus.hi, 32'h11);
        write_hilo(MTLO, 32'h22);
        check("mtlo_lo", bus.lo, 32'h22);
        check("mt_busy", 32'(bus.busy), 32'h0);

        issue(DIVU, 32'h7, 32'h0);
        push("divu_zero", 32'h11, 32'h22, 10);
        wait_done(0);

        // Start and MTHI/MTLO writes during an op must be ignored.
        issue(MULT, 32'h6, 32'h7);
        push("mult_busy", 32'h0, 32'd42, 5);
        bus.start = 1'b1;
        bus.md_op = DIV;
        bus.a     = 32'h100;
        bus.b     = 32'h3;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.we_hilo = 1'b1;
        bus.md_op   = MTHI;
        bus.a       = 32'hdead_beef;
        @(posedge clk);
        #1;
        bus.we_hilo = 1'b0;
        bus.md_op   = NONE;
        bus.a       = 32'h0;
        bus.b       = 32'h0;
        check("busy_ignore_hi", bus.hi, 32'h11);
        check("busy_ignore_lo", bus.lo, 32'h22);
        wait_done(2);

        // Asynchronous reset mid-DIV aborts the op and clears HI/LO.
        issue(DIV, 32'd1000, 32'd3);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_hi", bus.hi, 32'h0);
        check("abort_lo", bus.lo, 32'h0);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_after_busy", 32'(bus.busy), 32'h0);
        check("abort_after_lo", bus.lo, 32'h0);

        write_hilo(MTHI, 32'h0);
        write_hilo(MTLO, 32'hffff_ffff);
        issue(MADDU, 32'h1, 32'h1);
`ifdef MD_MADD_EN
        push("maddu", 32'h1, 32'h0, 5);
`else
        push("maddu", 32'h0, 32'hffff_ffff, 0);
`endif
        wait_done(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
